// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: imem request/response, redirect and decode handshake bundle.
interface inst_fetch_queue_if #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    modport master (
        output imem_req, imem_addr, out_valid, out_inst, out_pc,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_req, imem_addr, out_valid, out_inst, out_pc,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC, 1-cycle imem requests and DEPTH-entry {inst,pc} FIFO to decode.
// Optional FETCH_STALL_CNT_EN adds stall_cnt_o, counting cycles fetch is throttled by a full FIFO.
module inst_fetch_queue #(
    parameter int                ADDR_W   = 8,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_queue_if.master  bus
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_q, pc_d, inflight_pc_q;
    logic              inflight_q, squash_q;
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              pop, push, req;

    assign bus.out_valid = !rst && !bus.redirect_valid && count_q != '0;
    assign bus.out_inst  = inst_mem_q[rd_ptr_q];
    assign bus.out_pc    = pc_mem_q[rd_ptr_q];
    assign pop  = bus.out_valid && bus.out_ready;
    assign push = inflight_q && !squash_q;
    // A same-cycle pop frees a slot, so a full queue being drained keeps fetching.
    assign req  = !rst && !bus.redirect_valid &&
                  ((CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop) < (CW+1)'(DEPTH));
    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign pc_d    = req ? pc_q + ADDR_W'(PC_STEP) : pc_q;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
            squash_q      <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else if (bus.redirect_valid) begin
            pc_q       <= bus.redirect_pc;
            inflight_q <= 1'b0;
            squash_q   <= inflight_q;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= req;
            squash_q      <= 1'b0;
            inflight_pc_q <= req ? pc_q : inflight_pc_q;
            count_q       <= count_d;
            rd_ptr_q      <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
            wr_ptr_q      <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else if (!bus.redirect_valid && !req) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule
